seg7_scan_controller: RTL and testbench
=======================================

SEG7_SCAN_CONTROLLER -- requirements
Module: seg7_scan_controller

Interface
REQ-001 The block SHALL have parameter DIV, default 1000: ON-time per digit in clk cycles; legal values are 2 or more.
REQ-002 The block SHALL have parameter GUARD, default 16: all-anodes-off interval between digits in clk cycles; legal values are 1 or more.
REQ-003 clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 en  in  1  scan enable; 0 = display dark.
REQ-006 load  in  1  one-cycle strobe; data SHALL be captured on this cycle.
REQ-007 data  in  16  four hex digits; digit k = data[4k+3:4k].
REQ-008 blank  in  4  per-digit blank mask; 1 = digit k is never lit.
REQ-009 nibble  out  4  hex code to the 7-segment decoder inputs (bit 0 = B0).
REQ-010 an  out  4  active-low digit anodes, one-hot low when lit.
REQ-011 digit  out  2  index of the current digit.
REQ-012 frame_done  out  1  one-cycle pulse per completed 4-digit frame.

Function
REQ-013 All outputs SHALL be registered; no input SHALL reach an output combinationally.
REQ-014 Internal state SHALL be: FSM {OFF, ON, GUARD}; digit counter 0..3; cycle counter; 16-bit shadow register; 16-bit active register; pending flag.
REQ-015 OFF: an=1111, nibble=0, digit=0; on an edge with en=1, next state SHALL be ON with digit 0.
REQ-016 ON: an[digit]=0 and other bits 1, unless blank[digit]=1 (then an=1111); nibble = active[4*digit+3:4*digit]; lasts exactly DIV cycles, then GUARD.
REQ-017 GUARD: an=1111; nibble holds the value from ON; lasts exactly GUARD cycles, then ON with digit+1 mod 4.
REQ-018 Digit period SHALL be DIV+GUARD cycles; frame period SHALL be 4*(DIV+GUARD) cycles.
REQ-019 Frame boundary = last GUARD cycle of digit 3; frame_done SHALL be 1 on the first ON cycle of the following digit 0 only.
REQ-020 load in ON/GUARD, off-boundary: shadow<=data, pending<=1; active SHALL be unchanged until the boundary.
REQ-021 At the boundary with pending=1 and load=0: active<=shadow, pending<=0.
REQ-022 load on the boundary cycle: active<=data directly, pending<=0; the new load SHALL win over any older shadow.
REQ-023 Multiple loads within one frame: the last one SHALL win.
REQ-024 load in OFF: active<=data immediately, pending<=0.
REQ-025 en=0 in ON/GUARD: next cycle SHALL be OFF, counters cleared, frame_done=0; active and pending SHALL be kept.
REQ-026 blank SHALL be sampled every cycle; a change SHALL take effect on the next an update.

Reset
REQ-027 With reset=1 on an edge, the next cycle SHALL show state OFF, an=1111, nibble=0, digit=0, frame_done=0, with active, shadow and pending cleared.
REQ-028 Reset SHALL override en and load on the same edge.
REQ-029 Reset mid-scan SHALL discard any pending data.

Verification (DIV=4, GUARD=2)
REQ-030 Reset, then load 16'h1234 in OFF, then en=1 -> an/nibble: 1110/4 for 4 cycles, 1111 for 2, 1101/3 for 4, 1111 for 2, 1011/2, then 0111/1; frame_done 24 cycles after the first ON cycle.
REQ-031 Active 1234; load ABCD during digit 1 -> digits 2 and 3 still show 2 and 1; after frame_done, nibble sequence is D, C, B, A.
REQ-032 Loads 5555 then 6666 within one frame -> the next frame shows 6 on all digits.
REQ-033 load 9999 exactly on the boundary cycle while pending=1 with 7777 -> the next frame shows 9s and pending=0.
REQ-034 en drops during digit 2 ON -> an=1111 on the next cycle; re-enable -> restarts at digit 0 with active unchanged; blank=0100 -> digit 2 is never lit.
REQ-035 reset pulse during digit 3 with a load pending -> the next cycle matches the REQ-027 values; re-enable -> nibble=0 on all digits.

Source files
------------

// File: rtl/seg7_if.sv
// seg7_if -- bundle of the scan controller's control inputs and display outputs.
//
// Signals
//   en          scan enable (0 = display dark)
//   load        one-cycle strobe; data is captured on the cycle it is high
//   data[15:0]  four hex digits, digit k = data[4k+3:4k]
//   blank[3:0]  per-digit blank mask, 1 = digit never lit
//   nibble[3:0] hex code towards the 7-segment decoder
//   an[3:0]     active-low anodes, one-hot low when a digit is lit
//   digit[1:0]  index of the digit currently being scanned
//   frame_done  one-cycle pulse on the first ON cycle after a full frame
//   dbg_state   scan FSM state (0 = OFF, 1 = ON, 2 = GUARD)
//   dbg_pending 1 while a loaded value waits in the shadow register
//
// Handshake: there is no back-pressure. A load strobe is always accepted on
// the clock edge where it is high; the displayed value changes at the next
// frame boundary while scanning, or immediately while the scan is off.
//
// master: the side that drives the controls (testbench / host logic)
// slave : the scan controller
interface seg7_if;
  logic        en;
  logic        load;
  logic [15:0] data;
  logic [3:0]  blank;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic [1:0]  digit;
  logic        frame_done;
  logic [1:0]  dbg_state;
  logic        dbg_pending;

  modport master (
    output en, load, data, blank,
    input  nibble, an, digit, frame_done, dbg_state, dbg_pending
  );

  modport slave (
    input  en, load, data, blank,
    output nibble, an, digit, frame_done, dbg_state, dbg_pending
  );
endinterface

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller -- time-multiplexed driver for a 4-digit 7-segment display.
//
// Each digit is lit for DIV cycles, followed by GUARD cycles with all anodes
// off, so the digit period is DIV+GUARD and a frame is 4*(DIV+GUARD) cycles.
// New data loaded while scanning is held in a shadow register and copied into
// the displayed (active) register only at a frame boundary, so a frame never
// shows a mix of old and new digits.
//
// Ports
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous active-high reset
//   bus    seg7_if slave modport (controls in, display outputs out)
//
// Parameters
//   DIV    ON-time per digit in clk cycles (>= 2)
//   GUARD  all-off interval between digits in clk cycles (>= 1)
module seg7_scan_controller #(
  parameter int DIV   = 1000,
  parameter int GUARD = 16
) (
  input logic   clk,
  input logic   reset,
  seg7_if.slave bus
);

  localparam int CMAX = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] ON_LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t        state_q,      state_d;
  logic [1:0]    digit_q,      digit_d;
  logic [CW-1:0] cnt_q,        cnt_d;
  logic [15:0]   shadow_q,     shadow_d;
  logic [15:0]   active_q,     active_d;
  logic          pending_q,    pending_d;
  logic [3:0]    an_q,         an_d;
  logic [3:0]    nibble_q,     nibble_d;
  logic          frame_done_q, frame_done_d;

  // Last GUARD cycle of digit 3: the only cycle where active may be replaced
  // while scanning.
  logic boundary;
  assign boundary = (state_q == ST_GUARD) && (digit_q == 2'd3) && (cnt_q == GUARD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_OFF;
      digit_q      <= 2'd0;
      cnt_q        <= '0;
      shadow_q     <= 16'h0000;
      active_q     <= 16'h0000;
      pending_q    <= 1'b0;
      an_q         <= 4'hF;
      nibble_q     <= 4'h0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      nibble_q     <= nibble_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state: scan sequencing
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (bus.en) begin
          state_d = ST_ON;
          digit_d = 2'd0;
          cnt_d   = '0;
        end
      end
      ST_ON: begin
        if (!bus.en) begin
          state_d = ST_OFF;
          digit_d = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == ON_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GUARD: begin
        if (!bus.en) begin
          state_d = ST_OFF;
          digit_d = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == GUARD_LAST) begin
          state_d      = ST_ON;
          digit_d      = digit_q + 2'd1;
          cnt_d        = '0;
          // Wrapping from digit 3 to digit 0 completes a frame.
          frame_done_d = (digit_q == 2'd3);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        digit_d = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Next-state: display data registers
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (state_q == ST_OFF) begin
      if (bus.load) begin
        active_d  = bus.data;
        pending_d = 1'b0;
      end
    end else if (boundary) begin
      // A load on the boundary itself is newer than anything in the shadow.
      if (bus.load) begin
        active_d  = bus.data;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (bus.load) begin
      shadow_d  = bus.data;
      pending_d = 1'b1;
    end
  end

  // Registered outputs are computed from the next state so they line up with
  // the state they describe.
  always_comb begin
    an_d     = 4'hF;
    nibble_d = 4'h0;
    case (state_d)
      ST_ON: begin
        nibble_d = active_d[{digit_d, 2'b00} +: 4];
        if (!bus.blank[digit_d]) an_d = ~(4'b0001 << digit_d);
      end
      ST_GUARD: nibble_d = nibble_q;
      default:  nibble_d = 4'h0;
    endcase
  end

  assign bus.an          = an_q;
  assign bus.nibble      = nibble_q;
  assign bus.digit       = digit_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller -- directed bench for seg7_scan_controller with
// DIV=4, GUARD=2. Expected display tuples {an, nibble, digit, frame_done} are
// queued frame by frame and compared one per clock.
module tb_seg7_scan_controller;
  localparam int DIV   = 4;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * (DIV + GUARD);
  localparam int W     = 11;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   ncyc;
  logic [W-1:0] exp_q[$];

  seg7_if bus ();

  seg7_scan_controller #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver / scoreboard tasks
  task automatic push_entry(input logic [3:0] an_v, input logic [3:0] nib,
                            input logic [1:0] dig, input logic fd);
    exp_q.push_back({an_v, nib, dig, fd});
  endtask

  task automatic push_off();
    push_entry(4'hF, 4'h0, 2'd0, 1'b0);
  endtask

  // Queue the first npos cycles of a frame showing value v with blank mask bl.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] bl,
                            input logic fd0, input int npos);
    int pos;
    logic [3:0] an_v;
    pos = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < DIV + GUARD; i++) begin
        if (pos < npos) begin
          an_v = 4'hF;
          if (i < DIV && !bl[k]) an_v = ~(4'b0001 << k);
          push_entry(an_v, v[4*k +: 4], 2'(k), fd0 && (k == 0) && (i == 0));
        end
        pos++;
      end
    end
  endtask

  task automatic cyc();
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    @(posedge clk);
    @(negedge clk);
    ncyc++;
    got_v = {bus.an, bus.nibble, bus.digit, bus.frame_done};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scan_underflow: got %h with no expected entry at cycle %0d", got_v, ncyc);
    end else begin
      exp_v = exp_q.pop_front();
      assert (got_v === exp_v)
        else begin
          errors++;
          $error("FAIL scan: got {an,nib,dig,fd}=%h expected %h at cycle %0d", got_v, exp_v, ncyc);
        end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic check_pending(input logic exp_p, input string tag);
    checks++;
    assert (bus.dbg_pending === exp_p)
      else begin
        errors++;
        $error("FAIL %s: pending got %b expected %b", tag, bus.dbg_pending, exp_p);
      end
  endtask

  task automatic strobe(input logic [15:0] d);
    bus.load = 1'b1;
    bus.data = d;
    cyc();
    bus.load = 1'b0;
  endtask

  // directed sequence
  initial begin
    checks    = 0;
    errors    = 0;
    ncyc      = 0;
    reset     = 1'b1;
    bus.en    = 1'b0;
    bus.load  = 1'b0;
    bus.data  = 16'h0000;
    bus.blank = 4'b0000;

    // Reset state
    push_off();
    cyc();
    check_pending(1'b0, "reset_pending");
    reset = 1'b0;

    // Load in OFF, then scan: 4 lit / 2 dark per digit, frame_done after 24
    push_off();
    strobe(16'h1234);
    bus.en = 1'b1;
    push_frame(16'h1234, 4'b0000, 1'b0, FRAME);
    run(FRAME);

    // Load during digit 1 is deferred to the next frame
    push_frame(16'h1234, 4'b0000, 1'b1, FRAME);
    run(7);
    strobe(16'hABCD);
    run(16);
    check_pending(1'b1, "abcd_pending");
    push_frame(16'hABCD, 4'b0000, 1'b1, FRAME);
    run(FRAME);
    check_pending(1'b0, "abcd_applied");

    // Two loads in one frame: the last one wins
    push_frame(16'hABCD, 4'b0000, 1'b1, FRAME);
    run(3);
    strobe(16'h5555);
    run(11);
    strobe(16'h6666);
    run(8);

    // Load on the boundary cycle beats the pending shadow value
    push_frame(16'h6666, 4'b0000, 1'b1, FRAME);
    run(5);
    strobe(16'h7777);
    run(18);
    check_pending(1'b1, "pending_7777");
    push_frame(16'h9999, 4'b0000, 1'b1, FRAME);
    strobe(16'h9999);
    check_pending(1'b0, "boundary_load");
    run(FRAME - 1);

    // Drop enable during digit 2 ON, then restart with digit 2 blanked
    push_frame(16'h9999, 4'b0000, 1'b1, 14);
    run(14);
    bus.en = 1'b0;
    push_off();
    push_off();
    run(2);
    bus.blank = 4'b0100;
    bus.en    = 1'b1;
    push_frame(16'h9999, 4'b0100, 1'b0, FRAME);
    run(FRAME);
    push_frame(16'h9999, 4'b0100, 1'b1, FRAME);
    run(FRAME);

    // Reset during digit 3 with a load pending; reset also beats en and load
    push_frame(16'h9999, 4'b0100, 1'b1, 19);
    run(5);
    strobe(16'h1111);
    run(13);
    check_pending(1'b1, "pending_1111");
    reset    = 1'b1;
    bus.load = 1'b1;
    bus.data = 16'hFFFF;
    push_off();
    cyc();
    reset    = 1'b0;
    bus.load = 1'b0;
    check_pending(1'b0, "reset_discard");
    push_frame(16'h0000, 4'b0100, 1'b0, FRAME);
    run(FRAME);
    bus.en = 1'b0;
    push_off();
    cyc();

    checks++;
    assert (exp_q.size() == 0)
      else begin
        errors++;
        $error("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
      end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
